// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: round-robin arbitration of NUM_REQ writeback sources onto the single
// regfile write port, plus a busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_sched #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RA_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [RA_W-1:0]          issue_rs1,
  input  logic [RA_W-1:0]          issue_rs2,
  input  logic [RA_W-1:0]          issue_rd,
  output logic                     issue_ready,
  input  logic [NUM_REQ-1:0]       wb_valid,
  input  logic [NUM_REQ*RA_W-1:0]  wb_rd,
  input  logic [NUM_REQ*XLEN-1:0]  wb_data,
  output logic [NUM_REQ-1:0]       wb_ready,
  output logic [RA_W-1:0]          rf_rd,
  output logic [XLEN-1:0]          rf_rd_data,
  output logic                     rf_rd_en,
  output logic [2**RA_W-1:0]       busy,
  output logic                     wb_err
);

  localparam int unsigned NRegs = 2**RA_W;
  localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NRegs-1:0] busy_q, busy_d;
  logic [RA_W-1:0]  rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_rd_data_q, rf_rd_data_d;
  logic             rf_rd_en_q, rf_rd_en_d;
  logic             wb_err_q, wb_err_d;

  logic             gnt_valid;
  logic [PtrW-1:0]  gnt_idx;
  logic [RA_W-1:0]  gnt_rd;
  logic [XLEN-1:0]  gnt_data;

  // Two passes: indices at/after the pointer first, then the wrapped-around lower indices.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_rd    = '0;
    gnt_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_valid && wb_valid[i] && (PtrW'(i) >= rr_ptr_q)) begin
        gnt_valid = 1'b1;
        gnt_idx   = PtrW'(i);
        gnt_rd    = wb_rd[i*RA_W +: RA_W];
        gnt_data  = wb_data[i*XLEN +: XLEN];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_valid && wb_valid[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PtrW'(i);
        gnt_rd    = wb_rd[i*RA_W +: RA_W];
        gnt_data  = wb_data[i*XLEN +: XLEN];
      end
    end
    if (rst) begin
      gnt_valid = 1'b0;
    end
  end

  always_comb begin
    wb_ready = '0;
    if (gnt_valid) begin
      wb_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) begin
      rr_ptr_d = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + PtrW'(1);
    end
  end

  always_comb begin
    issue_ready = !(busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
  end

  // Busy clears off the registered write, so a reader that first sees busy=0 also sees the
  // committed regfile value. A same-cycle issue to that register wins over the clear.
  always_comb begin
    busy_d = busy_q;
    if (rf_rd_en_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rf_rd_d      = rf_rd_q;
    rf_rd_data_d = rf_rd_data_q;
    rf_rd_en_d   = 1'b0;
    wb_err_d     = wb_err_q;
    if (gnt_valid) begin
      rf_rd_d      = gnt_rd;
      rf_rd_data_d = gnt_data;
      rf_rd_en_d   = (gnt_rd != '0);
      if ((gnt_rd != '0) && !busy_q[gnt_rd]) begin
        wb_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      busy_q       <= '0;
      rf_rd_q      <= '0;
      rf_rd_data_q <= '0;
      rf_rd_en_q   <= 1'b0;
      wb_err_q     <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= busy_d;
      rf_rd_q      <= rf_rd_d;
      rf_rd_data_q <= rf_rd_data_d;
      rf_rd_en_q   <= rf_rd_en_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign rf_rd      = rf_rd_q;
  assign rf_rd_data = rf_rd_data_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign busy       = busy_q;
  assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural scoreboard/arbiter model.
module tb_regfile_wb_sched;

  localparam int NUM_REQ = 3;
  localparam int XLEN    = 32;
  localparam int RA_W    = 5;
  localparam int NREGS   = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    issue_valid;
  logic [RA_W-1:0]         issue_rs1, issue_rs2, issue_rd;
  logic                    issue_ready;
  logic [NUM_REQ-1:0]      wb_valid;
  logic [NUM_REQ*RA_W-1:0] wb_rd;
  logic [NUM_REQ*XLEN-1:0] wb_data;
  logic [NUM_REQ-1:0]      wb_ready;
  logic [RA_W-1:0]         rf_rd;
  logic [XLEN-1:0]         rf_rd_data;
  logic                    rf_rd_en;
  logic [NREGS-1:0]        busy;
  logic                    wb_err;

  regfile_wb_sched #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rs1  (issue_rs1),
    .issue_rs2  (issue_rs2),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .rf_rd      (rf_rd),
    .rf_rd_data (rf_rd_data),
    .rf_rd_en   (rf_rd_en),
    .busy       (busy),
    .wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Behavioural model: a busy set, a pointer, and the last write presented on the port.
  logic [NREGS-1:0] m_busy;
  int               m_ptr;
  logic [RA_W-1:0]  m_rf_rd;
  logic [XLEN-1:0]  m_rf_data;
  bit               m_rf_en;
  bit               m_err;
  int               m_last_g = -1;
  bit               m_init   = 0;

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j = (m_ptr + k) % NUM_REQ;
      if (wb_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit model_issue_ready();
    return !(m_busy[issue_rs1] || m_busy[issue_rs2] || m_busy[issue_rd]);
  endfunction

  task automatic model_step();
    int g;
    logic [NREGS-1:0] nb;
    logic [RA_W-1:0] rd;
    if (rst) begin
      m_busy = '0; m_ptr = 0; m_rf_rd = '0; m_rf_data = '0;
      m_rf_en = 0; m_err = 0; m_last_g = -1; m_init = 1;
      return;
    end
    g  = model_grant();
    nb = m_busy;
    // A register is released at the edge ending the cycle its write sits on the port.
    if (m_rf_en) nb[m_rf_rd] = 1'b0;
    if (issue_valid && model_issue_ready() && issue_rd != 0) nb[issue_rd] = 1'b1;
    if (g >= 0) begin
      rd = wb_rd[g*RA_W +: RA_W];
      if (rd != 0 && !m_busy[rd]) m_err = 1;
      m_rf_rd   = rd;
      m_rf_data = wb_data[g*XLEN +: XLEN];
      m_rf_en   = (rd != 0);
      m_ptr     = (g + 1) % NUM_REQ;
    end else begin
      m_rf_en = 0;
    end
    m_busy   = nb;
    m_last_g = g;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    int g;
    @(negedge clk);
    if (m_init) begin
      g = model_grant();
      check("wb_ready", wb_ready, (g < 0) ? 0 : (1 << g));
      check("issue_ready", issue_ready, model_issue_ready());
      check("rf_rd_en", rf_rd_en, m_rf_en);
      check("rf_rd", rf_rd, m_rf_rd);
      check("rf_rd_data", rf_rd_data, m_rf_data);
      check("busy", busy, m_busy);
      check("wb_err", wb_err, m_err);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit v, input logic [RA_W-1:0] rd,
                         input logic [XLEN-1:0] d);
    wb_valid[i] = v;
    wb_rd[i*RA_W +: RA_W] = rd;
    wb_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic set_issue(input bit v, input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                           input logic [RA_W-1:0] rd);
    issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
  endtask

  bit              pend    [NUM_REQ];
  bit              claimed [NREGS];
  logic [2:0]      rr_exp  [6];
  logic [RA_W-1:0] pick;

  initial begin
    rst = 1'b1;
    wb_valid = '1; wb_rd = '0; wb_data = '0;
    set_issue(0, 0, 0, 0);

    // Reset with every requester asserting
    cyc(); cyc();
    mid();
    check("rst_wb_ready", wb_ready, 3'b000);
    check("rst_rf_rd_en", rf_rd_en, 1'b0);
    check("rst_busy", busy, 32'h0);
    check("rst_wb_err", wb_err, 1'b0);
    cyc();
    rst = 1'b0; wb_valid = '0;

    // RAW stall on x5 and its writeback
    set_issue(1, 0, 0, 5);
    mid();
    check("t2_issue_ready_free", issue_ready, 1'b1);
    cyc();
    set_issue(1, 5, 0, 0);
    set_req(1, 1, 5, 32'hDEAD_BEEF);
    mid();
    check("t2_busy5", busy, 32'h0000_0020);
    check("t2_raw_stall", issue_ready, 1'b0);
    check("t2_grant", wb_ready, 3'b010);
    cyc();
    set_req(1, 0, 0, 0);
    mid();
    check("t2_rf_rd", rf_rd, 5);
    check("t2_rf_data", rf_rd_data, 32'hDEAD_BEEF);
    check("t2_rf_en", rf_rd_en, 1'b1);
    check("t2_still_stalled", issue_ready, 1'b0);
    cyc();
    mid();
    check("t2_busy_clear", busy, 32'h0);
    check("t2_ready_after", issue_ready, 1'b1);
    cyc();
    set_issue(0, 0, 0, 0);

    // Round robin from pointer 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1, 0, 32'(i + 100));
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int k = 0; k < 6; k++) begin
      mid();
      check("t3_rr_order", wb_ready, rr_exp[k]);
      cyc();
    end
    mid();
    check("t3_grant0", wb_ready, 3'b001);
    cyc();
    wb_valid = 3'b101;
    mid();
    check("t3_skip_to2", wb_ready, 3'b100);
    cyc();
    wb_valid = '0;

    // x0 handling
    set_issue(1, 0, 0, 0);
    set_req(0, 1, 0, 32'h5555_0000);
    mid();
    check("t4_x0_ready", issue_ready, 1'b1);
    cyc();
    set_req(0, 0, 0, 0);
    set_issue(1, 0, 0, 3);
    mid();
    check("t4_busy_unchanged", busy, 32'h0);
    check("t4_x0_wb_no_en", rf_rd_en, 1'b0);
    check("t4_x0_no_err", wb_err, 1'b0);
    cyc();
    set_issue(1, 0, 0, 0);
    mid();
    check("t4_x0_ready_busy3", issue_ready, 1'b1);
    cyc();
    set_issue(0, 0, 0, 0);
    set_req(0, 1, 3, 32'h0000_0003);
    cyc();
    set_req(0, 0, 0, 0);
    cyc();

    // Writeback to a non-busy register
    set_req(0, 1, 7, 32'h1234_5678);
    mid();
    check("t5_err_before", wb_err, 1'b0);
    cyc();
    set_req(0, 0, 0, 0);
    mid();
    check("t5_err_set", wb_err, 1'b1);
    check("t5_rf_en", rf_rd_en, 1'b1);
    check("t5_rf_rd", rf_rd, 7);
    cyc(); cyc();
    mid();
    check("t5_err_sticky", wb_err, 1'b1);

    // WAW stall and reset with a write in flight
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_issue(1, 0, 0, 9);
    cyc();
    set_req(0, 1, 9, 32'hCAFE_0009);
    mid();
    check("t6_busy9", busy, 32'h0000_0200);
    check("t6_waw_stall", issue_ready, 1'b0);
    check("t6_grant", wb_ready, 3'b001);
    cyc();
    rst = 1'b1;
    wb_valid = '1;
    mid();
    check("t6_rst_no_grant", wb_ready, 3'b000);
    check("t6_pending_write", rf_rd_en, 1'b1);
    cyc();
    rst = 1'b0;
    wb_valid = '0;
    set_issue(0, 0, 0, 0);
    mid();
    check("t6_busy_cleared", busy, 32'h0);
    check("t6_write_dropped", rf_rd_en, 1'b0);
    check("t6_err_clear", wb_err, 1'b0);

    // Randomized traffic; last stretch allows illegal destinations
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
    for (int r = 0; r < NREGS; r++) claimed[r] = 0;
    for (int c = 0; c < 2400; c++) begin
      cyc();
      if (m_last_g >= 0) pend[m_last_g] = 0;
      for (int r = 0; r < NREGS; r++) if (!m_busy[r]) claimed[r] = 0;
      rst = ($urandom_range(0, 399) == 0);
      if (rst) begin
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rst && !pend[i] && $urandom_range(0, 2) == 0) begin
          pick = RA_W'($urandom_range(1, 12));
          if (!(m_busy[pick] && !claimed[pick])) pick = '0;
          if (c >= 2000 && $urandom_range(0, 3) == 0) pick = RA_W'($urandom_range(0, 31));
          if (pick != 0) claimed[pick] = 1;
          pend[i] = 1;
          set_req(i, 1, pick, $urandom);
        end else if (!pend[i]) begin
          wb_valid[i] = 1'b0;
        end
      end
      set_issue($urandom_range(0, 1), RA_W'($urandom_range(0, 12)),
                RA_W'($urandom_range(0, 12)), RA_W'($urandom_range(0, 12)));
    end
    cyc();
    mid();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
